poly_sound_card: RTL and testbench

- Parametrised N-channel tone generator and mixer; successor to the fixed 4-channel sound card.
- Each channel has a phase accumulator and a runtime-selectable waveform: square, sawtooth, triangle or LFSR noise. Each channel also has a volume and an enable.
- Channels are configured through a register write port instead of switch inputs.
- Produces one mixed, averaged sample per sample tick, with a valid strobe, for the downstream DAC/PWM stage.

---
 rtl/poly_sound_card_if.sv | 25 ++
 rtl/poly_sound_card.sv | 221 ++++++++++++++++++++++
 tb/tb_poly_sound_card.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_sound_card_if.sv
// poly_sound_card_if: channel config write port and mixed
// sample output of the poly_sound_card tone generator.
interface poly_sound_card_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_addr;
  logic [15:0]         cfg_data;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_valid;

  modport master (
    output cfg_we, cfg_ch, cfg_addr, cfg_data,
    input  sample_out, sample_valid
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_addr, cfg_data,
    output sample_out, sample_valid
  );
endinterface

// File: rtl/poly_sound_card.sv
// poly_sound_card: N-channel tone generator + averaging mixer.
// Optional envelope decay: define POLY_SOUND_ENVELOPE_EN.
module poly_sound_card #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 16,
  parameter int DIV      = 256
) (
  input  logic              clk,
  input  logic              reset,
  poly_sound_card_if.slave  bus
);
  localparam int LOG_CH = $clog2(NUM_CH);
  localparam int CH_W   = (NUM_CH > 1) ? LOG_CH : 1;
  localparam int SUM_W  = SAMPLE_W + LOG_CH;
  localparam int CNT_W  = $clog2(DIV);
  localparam int PRD_W  = SAMPLE_W + 5;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick;
  logic [ACC_W-1:0]    inc_q [NUM_CH], inc_d [NUM_CH];
  logic [1:0]          mode_q [NUM_CH], mode_d [NUM_CH];
  logic                en_q [NUM_CH], en_d [NUM_CH];
  logic [4:0]          vol_q [NUM_CH], vol_d [NUM_CH];
  logic [ACC_W-1:0]    phase_q [NUM_CH], phase_d [NUM_CH];
  logic [15:0]         lfsr_q [NUM_CH], lfsr_d [NUM_CH];
  logic [1:0]          s_mode_q [NUM_CH], s_mode_d [NUM_CH];
  logic                s_en_q [NUM_CH], s_en_d [NUM_CH];
  logic [4:0]          s_vol_q [NUM_CH], s_vol_d [NUM_CH];
  logic [SAMPLE_W-1:0] scaled_q [NUM_CH], scaled_d [NUM_CH];
  logic                v1_q, v1_d, v2_q, v2_d;
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                sample_valid_q, sample_valid_d;
  logic [ACC_W:0]      add_t;
  logic [SAMPLE_W-1:0] wave;
  logic [PRD_W-1:0]    prod;
  logic [SUM_W-1:0]    sum_t;

`ifdef POLY_SOUND_ENVELOPE_EN
  logic [3:0]  decay_q [NUM_CH], decay_d [NUM_CH];
  logic [4:0]  env_q [NUM_CH], env_d [NUM_CH];
  logic [15:0] dcnt_q [NUM_CH], dcnt_d [NUM_CH];
  logic [16:0] dcnt_nx;
`endif

  assign tick = (cnt_q == CNT_W'(DIV - 1));

  // sample tick divider
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // channel register writes; out-of-range channels never match
  always_comb begin
    inc_d  = inc_q;
    mode_d = mode_q;
    en_d   = en_q;
    vol_d  = vol_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.cfg_we && bus.cfg_ch == CH_W'(c)) begin
        case (bus.cfg_addr)
          2'd0: inc_d[c] = ACC_W'(bus.cfg_data);
          2'd1: begin
            mode_d[c] = bus.cfg_data[1:0];
            en_d[c]   = bus.cfg_data[4];
          end
          2'd2: vol_d[c] = (bus.cfg_data[4:0] > 5'd16) ?
                           5'd16 : bus.cfg_data[4:0];
          default: ;
        endcase
      end
    end
  end

`ifdef POLY_SOUND_ENVELOPE_EN
  // envelope decay per tick; key-on write overrides the tick update
  always_comb begin
    decay_d = decay_q;
    env_d   = env_q;
    dcnt_d  = dcnt_q;
    dcnt_nx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (tick) begin
        dcnt_nx = {1'b0, dcnt_q[c]} + 17'd1;
        if (dcnt_nx == (17'd1 << decay_q[c])) begin
          dcnt_d[c] = '0;
          if (env_q[c] != 5'd0) env_d[c] = env_q[c] - 5'd1;
        end else begin
          dcnt_d[c] = dcnt_nx[15:0];
        end
      end
      if (bus.cfg_we && bus.cfg_ch == CH_W'(c)) begin
        if (bus.cfg_addr == 2'd1 && bus.cfg_data[4]) begin
          env_d[c]  = 5'd16;
          dcnt_d[c] = '0;
        end
        if (bus.cfg_addr == 2'd3) decay_d[c] = bus.cfg_data[3:0];
      end
    end
  end

  // envelope state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        decay_q[c] <= '0;
        env_q[c]   <= '0;
        dcnt_q[c]  <= '0;
      end
    end else begin
      decay_q <= decay_d;
      env_q   <= env_d;
      dcnt_q  <= dcnt_d;
    end
  end
`endif

  // stage 1: advance phases, step noise on carry, snapshot settings
  always_comb begin
    phase_d  = phase_q;
    lfsr_d   = lfsr_q;
    s_mode_d = s_mode_q;
    s_en_d   = s_en_q;
    s_vol_d  = s_vol_q;
    add_t    = '0;
    v1_d     = tick;
    if (tick) begin
      for (int c = 0; c < NUM_CH; c++) begin
        add_t      = {1'b0, phase_q[c]} + {1'b0, inc_q[c]};
        phase_d[c] = add_t[ACC_W-1:0];
        if (add_t[ACC_W]) begin
          lfsr_d[c] = {lfsr_q[c][14:0],
                       lfsr_q[c][15] ^ lfsr_q[c][13] ^
                       lfsr_q[c][12] ^ lfsr_q[c][10]};
        end
        s_mode_d[c] = mode_q[c];
        s_en_d[c]   = en_q[c];
`ifdef POLY_SOUND_ENVELOPE_EN
        s_vol_d[c]  = (vol_q[c] < env_q[c]) ? vol_q[c] : env_q[c];
`else
        s_vol_d[c]  = vol_q[c];
`endif
      end
    end
  end

  // stage 2: waveform shaping and volume scaling
  always_comb begin
    scaled_d = scaled_q;
    wave     = '0;
    prod     = '0;
    v2_d     = v1_q;
    if (v1_q) begin
      for (int c = 0; c < NUM_CH; c++) begin
        case (s_mode_q[c])
          2'd0: wave = phase_q[c][ACC_W-1] ? '1 : '0;
          2'd1: wave = phase_q[c][ACC_W-1 -: SAMPLE_W];
          2'd2: wave = phase_q[c][ACC_W-1] ?
                       ~phase_q[c][ACC_W-2 -: SAMPLE_W] :
                        phase_q[c][ACC_W-2 -: SAMPLE_W];
          default: wave = lfsr_q[c][SAMPLE_W-1:0];
        endcase
        prod = PRD_W'(wave) * PRD_W'(s_vol_q[c]);
        scaled_d[c] = s_en_q[c] ? prod[SAMPLE_W+3:4] : '0;
      end
    end
  end

  // stage 3: sum and floor-average into the output register
  always_comb begin
    sum_t          = '0;
    sample_out_d   = sample_out_q;
    sample_valid_d = v2_q;
    for (int c = 0; c < NUM_CH; c++) begin
      sum_t = sum_t + SUM_W'(scaled_q[c]);
    end
    if (v2_q) sample_out_d = SAMPLE_W'(sum_t >> LOG_CH);
  end

  // state registers; reset also drops any in-flight sample
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        inc_q[c]    <= '0;
        mode_q[c]   <= '0;
        en_q[c]     <= 1'b0;
        vol_q[c]    <= '0;
        phase_q[c]  <= '0;
        lfsr_q[c]   <= 16'hACE1 ^ 16'(c);
        s_mode_q[c] <= '0;
        s_en_q[c]   <= 1'b0;
        s_vol_q[c]  <= '0;
        scaled_q[c] <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      inc_q          <= inc_d;
      mode_q         <= mode_d;
      en_q           <= en_d;
      vol_q          <= vol_d;
      phase_q        <= phase_d;
      lfsr_q         <= lfsr_d;
      s_mode_q       <= s_mode_d;
      s_en_q         <= s_en_d;
      s_vol_q        <= s_vol_d;
      scaled_q       <= scaled_d;
    end
  end

  assign bus.sample_out   = sample_out_q;
  assign bus.sample_valid = sample_valid_q;
endmodule

// File: tb/tb_poly_sound_card.sv
// tb_poly_sound_card: directed tables, hand sequences and random
// config traffic checked against a per-tick arithmetic model.
module tb_poly_sound_card;
  localparam int NUM_CH = 4;
  localparam int SAMPLE_W = 8;
  localparam int ACC_W = 16;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  poly_sound_card_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) bus ();

  poly_sound_card #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W),
    .ACC_W(ACC_W), .DIV(DIV)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // reference model
  typedef struct { int due; int val; } pend_t;
  pend_t q[$];
  int unsigned m_inc [NUM_CH], m_phase [NUM_CH], m_lfsr [NUM_CH];
  int m_mode [NUM_CH], m_vol [NUM_CH], m_en [NUM_CH];
  int m_env [NUM_CH], m_dcnt [NUM_CH], m_decay [NUM_CH];
  int m_cnt = 0;
  int edge_no = 0;
  int exp_valid = 0;
  int exp_out = 0;

  function automatic int unsigned lfsr_step(int unsigned l);
    bit fb;
    fb = ^(l & 32'h0000_B400);
    return ((l << 1) | 32'(fb)) & 32'hFFFF;
  endfunction

  function automatic int wave_of(int mode, int unsigned ph,
                                 int unsigned lf);
    case (mode)
      0: return (ph >= 32768) ? 255 : 0;
      1: return int'(ph >> 8);
      2: return (ph < 32768) ? int'((ph >> 7) & 255)
                             : 255 - int'((ph >> 7) & 255);
      default: return int'(lf & 255);
    endcase
  endfunction

  always @(posedge clk) begin : model
    int sum;
    int ve;
    int c;
    int d;
    int unsigned nx;
    pend_t p;
    edge_no++;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_inc[i] = 0; m_phase[i] = 0; m_mode[i] = 0;
        m_en[i] = 0; m_vol[i] = 0;
        m_lfsr[i] = 32'hACE1 ^ 32'(i);
        m_env[i] = 0; m_dcnt[i] = 0; m_decay[i] = 0;
      end
      m_cnt = 0;
      q.delete();
      exp_valid = 0;
      exp_out = 0;
    end else begin
      if (m_cnt == DIV - 1) begin
        sum = 0;
        for (int i = 0; i < NUM_CH; i++) begin
          nx = m_phase[i] + m_inc[i];
          if (nx >= 65536) m_lfsr[i] = lfsr_step(m_lfsr[i]);
          m_phase[i] = nx % 65536;
          ve = m_vol[i];
`ifdef POLY_SOUND_ENVELOPE_EN
          if (m_env[i] < ve) ve = m_env[i];
`endif
          if (m_en[i] != 0)
            sum += wave_of(m_mode[i], m_phase[i], m_lfsr[i]) * ve / 16;
`ifdef POLY_SOUND_ENVELOPE_EN
          m_dcnt[i]++;
          if (m_dcnt[i] == (1 << m_decay[i])) begin
            m_dcnt[i] = 0;
            if (m_env[i] > 0) m_env[i]--;
          end
`endif
        end
        p.due = edge_no + 2;
        p.val = sum / NUM_CH;
        q.push_back(p);
      end
      if (bus.cfg_we === 1'b1) begin
        c = int'(bus.cfg_ch);
        d = int'(bus.cfg_data);
        case (bus.cfg_addr)
          2'd0: m_inc[c] = d;
          2'd1: begin
            m_mode[c] = d & 3;
            m_en[c] = (d >> 4) & 1;
`ifdef POLY_SOUND_ENVELOPE_EN
            if (m_en[c] != 0) begin
              m_env[c] = 16;
              m_dcnt[c] = 0;
            end
`endif
          end
          2'd2: m_vol[c] = ((d & 31) > 16) ? 16 : (d & 31);
          default: begin
`ifdef POLY_SOUND_ENVELOPE_EN
            m_decay[c] = d & 15;
`endif
          end
        endcase
      end
      m_cnt = (m_cnt + 1) % DIV;
      exp_valid = 0;
      if (q.size() > 0 && q[0].due == edge_no) begin
        exp_valid = 1;
        exp_out = q[0].val;
        void'(q.pop_front());
      end
    end
  end

  typedef struct {
    int ch; int mode; int inc; int vol; int en;
    logic [3:0][7:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  task automatic check(string nm, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (armed) begin
      check("model_valid", int'(bus.sample_valid), exp_valid);
      check("model_out", int'(bus.sample_out), exp_out);
    end
  endtask

  task automatic cfg(int ch, int a, int d);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = 2'(ch);
    bus.cfg_addr = 2'(a);
    bus.cfg_data = 16'(d);
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    armed = 1'b1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int v, output int n);
    v = -1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      n++;
      if (bus.sample_valid === 1'b1) begin
        v = int'(bus.sample_out);
        return;
      end
    end
    check("valid_timeout", 0, 1);
  endtask

  initial begin : stim
    vec_t tbl [7];
    int v;
    int n;
    bus.cfg_we = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;

    tbl[0] = '{0, 0, 'h8000, 16, 1, {8'd63, 8'd0, 8'd63, 8'd0}};
    tbl[1] = '{1, 1, 'h0100, 16, 1, {8'd0, 8'd0, 8'd0, 8'd1}};
    tbl[2] = '{3, 3, 'h8000, 16, 1, {8'd56, 8'd49, 8'd49, 8'd34}};
    tbl[3] = '{2, 2, 'h4000, 16, 1, {8'd32, 8'd63, 8'd31, 8'd0}};
    tbl[4] = '{0, 0, 'h8000, 8, 1, {8'd31, 8'd0, 8'd31, 8'd0}};
    tbl[5] = '{1, 0, 'h8000, 31, 1, {8'd63, 8'd0, 8'd63, 8'd0}};
    tbl[6] = '{0, 0, 'h8000, 16, 0, {8'd0, 8'd0, 8'd0, 8'd0}};

    // reset state, first latency and sample period
    do_reset();
    check("reset_out", int'(bus.sample_out), 0);
    check("reset_valid", int'(bus.sample_valid), 0);
    wait_valid(v, n);
    check("first_latency", n, 6);
    check("idle_s0", v, 0);
    wait_valid(v, n);
    check("period", n, DIV);
    check("idle_s1", v, 0);

    // single-channel table
    for (int t = 0; t < 7; t++) begin
      do_reset();
      cfg(tbl[t].ch, 0, tbl[t].inc);
      cfg(tbl[t].ch, 2, tbl[t].vol);
      cfg(tbl[t].ch, 1, (tbl[t].en << 4) | tbl[t].mode);
      for (int k = 0; k < 4; k++) begin
        wait_valid(v, n);
        check($sformatf("tbl%0d_s%0d", t, k), v,
              int'(tbl[t].exp[3-k]));
      end
    end

    // all channels square, then one volume halved
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      cfg(c, 1, 'h10);
      cfg(c, 2, 16);
    end
    wait_valid(v, n);
    step();
    for (int c = 0; c < NUM_CH; c++) cfg(c, 0, 'h8000);
    wait_valid(v, n);
    check("all4_hi", v, 255);
    wait_valid(v, n);
    check("all4_lo", v, 0);
    cfg(2, 2, 8);
    wait_valid(v, n);
    check("all4_vol8", v, 223);

    // write during the tick cycle lands one sample later
    do_reset();
    cfg(0, 2, 16);
    cfg(0, 1, 'h13);
    wait_valid(v, n);
    check("noise_hold", v, 56);
    step();
    cfg(0, 2, 0);
    wait_valid(v, n);
    check("tickwr_old", v, 56);
    wait_valid(v, n);
    check("tickwr_new", v, 0);

    // reset with a sample in flight
    do_reset();
    cfg(0, 2, 16);
    cfg(0, 1, 'h13);
    wait_valid(v, n);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("abort_valid", int'(bus.sample_valid), 0);
      check("abort_out", int'(bus.sample_out), 0);
    end

`ifdef POLY_SOUND_ENVELOPE_EN
    // key-on, fastest decay
    do_reset();
    cfg(0, 2, 16);
    cfg(0, 3, 0);
    cfg(0, 1, 'h13);
    wait_valid(v, n);
    check("env_first", v, 56);
    for (int k = 0; k < 19; k++) wait_valid(v, n);
    check("env_last", v, 0);
`endif

    // randomized config traffic with occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.cfg_we = ($urandom_range(0, 3) == 0);
      bus.cfg_ch = 2'($urandom_range(0, NUM_CH - 1));
      bus.cfg_addr = 2'($urandom_range(0, 3));
      bus.cfg_data = 16'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    bus.cfg_we = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
